// File: rtl/control_unit.sv
// Instruction sequencer for the 8-bit accumulator datapath: fetches 12-bit words,
// drives ALU code/immediate and register enables, and resolves carry jumps.
//
// state | meaning
// FETCH | latch pm_data into IR when run is high, else hold
// EXEC  | execute IR: ALU enables, jump resolution or HALT entry
// HALT  | absorbing stop; only Reset leaves it
module control_unit (
    input  logic        clk,
    input  logic        Reset,
    input  logic        run,
    input  logic [11:0] pm_data,
    input  logic        CY,
    output logic [7:0]  pm_addr,
    output logic [2:0]  ALUCode,
    output logic [7:0]  R,
    output logic        A_CE,
    output logic        CY_CE,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JC   = 3'b010;
    localparam logic [2:0] OP_JNC  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t      state, state_nxt;
    logic [7:0]  pc, pc_nxt;
    logic [11:0] ir, ir_nxt;
    logic [7:0]  pc_inc;
    logic        alu_exec;

    assign pc_inc = pc + 8'd1;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= FETCH;
            pc    <= 8'h00;
            ir    <= 12'h000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            FETCH: begin
                if (run) begin
                    ir_nxt    = pm_data;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = FETCH;
                pc_nxt    = pc_inc;
                if (ir[11]) begin
                    case (ir[10:8])
                        OP_JMP:  pc_nxt = ir[7:0];
                        OP_JC:   pc_nxt = CY ? ir[7:0] : pc_inc;
                        OP_JNC:  pc_nxt = CY ? pc_inc : ir[7:0];
                        OP_HALT: begin
                            pc_nxt    = pc;
                            state_nxt = HALT;
                        end
                        default: pc_nxt = pc_inc;
                    endcase
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // Reset masks the enables combinationally so a reset mid-EXEC writes nothing.
    assign alu_exec = (state == EXEC) & ~ir[11] & ~Reset;

    assign A_CE    = alu_exec;
    assign CY_CE   = alu_exec;
    assign pm_addr = pc;
    assign ALUCode = ir[10:8];
    assign R       = ir[7:0];
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, hand sequences for multi-cycle
// corners, and randomized programs checked against an instruction-level model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        Reset;
    logic        run;
    logic [11:0] pm_data;
    logic        CY;
    logic [7:0]  pm_addr;
    logic [2:0]  ALUCode;
    logic [7:0]  R;
    logic        A_CE;
    logic        CY_CE;
    logic        halted;

    logic [11:0] pmem [256];

    int checks   = 0;
    int failures = 0;

    control_unit dut (
        .clk     (clk),
        .Reset   (Reset),
        .run     (run),
        .pm_data (pm_data),
        .CY      (CY),
        .pm_addr (pm_addr),
        .ALUCode (ALUCode),
        .R       (R),
        .A_CE    (A_CE),
        .CY_CE   (CY_CE),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    assign pm_data = pmem[pm_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input logic [11:0] word);
        for (int i = 0; i < 256; i++) pmem[i] = word;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // Instruction-level reference: where the program counter goes after an instruction.
    function automatic logic [7:0] after_exec(input logic [11:0] ins, input logic [7:0] pc,
                                               input logic cy);
        int seq;
        seq = (int'(pc) + 1) % 256;
        if (!ins[11]) return 8'(seq);
        case (ins[10:8])
            3'd1:    return ins[7:0];
            3'd2:    return cy ? ins[7:0] : 8'(seq);
            3'd3:    return cy ? 8'(seq) : ins[7:0];
            3'd7:    return pc;
            default: return 8'(seq);
        endcase
    endfunction

    typedef struct {
        logic [11:0] instr;
        logic [7:0]  addr;
        logic        cy;
        logic [7:0]  exp_pc;
        logic        exp_ce;
        logic        exp_halt;
    } vec_t;

    vec_t vecs [11];

    // model state for the random phase
    logic [7:0]  m_pc;
    logic [11:0] m_ir;
    bit          m_pending;
    bit          m_stopped;

    initial begin
        Reset = 1'b0;
        run   = 1'b0;
        CY    = 1'b0;
        fill_mem(12'h800);

        vecs[0]  = '{12'hA20, 8'h05, 1'b1, 8'h20, 1'b0, 1'b0};  // JC taken
        vecs[1]  = '{12'hA20, 8'h05, 1'b0, 8'h06, 1'b0, 1'b0};  // JC not taken
        vecs[2]  = '{12'hB20, 8'h05, 1'b0, 8'h20, 1'b0, 1'b0};  // JNC taken
        vecs[3]  = '{12'hB20, 8'h05, 1'b1, 8'h06, 1'b0, 1'b0};  // JNC not taken
        vecs[4]  = '{12'h940, 8'h10, 1'b0, 8'h40, 1'b0, 1'b0};  // JMP
        vecs[5]  = '{12'h800, 8'h10, 1'b1, 8'h11, 1'b0, 1'b0};  // NOP
        vecs[6]  = '{12'hC55, 8'h10, 1'b0, 8'h11, 1'b0, 1'b0};  // op 100 as NOP
        vecs[7]  = '{12'h3AB, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0};  // ALU at 0xFF wraps
        vecs[8]  = '{12'hF00, 8'h30, 1'b0, 8'h30, 1'b0, 1'b1};  // HALT
        vecs[9]  = '{12'h905, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0};  // self jump
        vecs[10] = '{12'h6E1, 8'h22, 1'b1, 8'h23, 1'b1, 1'b0};  // ALU code 6

        // ---- test plan sequence 1: ALU then HALT ----
        fill_mem(12'h800);
        pmem[0] = 12'h008;
        pmem[1] = 12'hF00;
        run = 1'b1;
        do_reset();
        chk("reset_pm_addr", pm_addr, 8'h00);
        chk("reset_alucode", ALUCode, 3'd0);
        chk("reset_r", R, 8'h00);
        chk("reset_halted", halted, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            chk("seq1_a_ce", A_CE, (c == 2));
            chk("seq1_cy_ce", CY_CE, (c == 2));
            chk("seq1_halted", halted, (c >= 5));
            if (c == 2) begin
                chk("seq1_alucode", ALUCode, 3'd0);
                chk("seq1_r", R, 8'h08);
            end
            if (c >= 3) chk("seq1_pm_addr", pm_addr, 8'h01);
            tick();
        end

        // ---- directed table: JMP from 0 to addr, then execute instr there ----
        foreach (vecs[i]) begin
            fill_mem(12'h800);
            pmem[0] = {4'h9, vecs[i].addr};
            pmem[vecs[i].addr] = vecs[i].instr;
            CY  = vecs[i].cy;
            run = 1'b1;
            do_reset();
            tick();
            tick();
            chk("vec_fetch_addr", pm_addr, vecs[i].addr);
            tick();
            chk("vec_a_ce", A_CE, vecs[i].exp_ce);
            chk("vec_cy_ce", CY_CE, vecs[i].exp_ce);
            chk("vec_alucode", ALUCode, vecs[i].instr[10:8]);
            chk("vec_r", R, vecs[i].instr[7:0]);
            tick();
            chk("vec_pc_after", pm_addr, vecs[i].exp_pc);
            chk("vec_halted", halted, vecs[i].exp_halt);
        end

        // ---- run held low in FETCH at 0x03 ----
        fill_mem(12'h800);
        pmem[3] = 12'h1AA;
        run = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) tick();
        chk("hold_start_addr", pm_addr, 8'h03);
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_pm_addr", pm_addr, 8'h03);
            chk("hold_a_ce", A_CE, 1'b0);
            chk("hold_cy_ce", CY_CE, 1'b0);
        end
        run = 1'b1;
        tick();
        chk("resume_a_ce", A_CE, 1'b1);
        chk("resume_r", R, 8'hAA);
        run = 1'b0;  // dropping run during EXEC must not abort it
        tick();
        chk("resume_pm_addr", pm_addr, 8'h04);

        // ---- Reset during EXEC of an ALU op ----
        fill_mem(12'h800);
        pmem[0] = 12'h2C3;
        run = 1'b1;
        do_reset();
        tick();
        chk("pre_rst_a_ce", A_CE, 1'b1);
        Reset = 1'b1;
        #1;
        chk("rst_exec_a_ce", A_CE, 1'b0);
        chk("rst_exec_cy_ce", CY_CE, 1'b0);
        tick();
        Reset = 1'b0;
        run   = 1'b0;
        chk("rst_exec_pm_addr", pm_addr, 8'h00);
        chk("rst_exec_r", R, 8'h00);
        chk("rst_exec_halted", halted, 1'b0);
        tick();
        run = 1'b1;
        tick();
        chk("rst_refetch_a_ce", A_CE, 1'b1);
        chk("rst_refetch_r", R, 8'hC3);

        // ---- HALT is absorbing ----
        fill_mem(12'h800);
        pmem[0] = 12'h5E7;
        pmem[1] = 12'hF12;
        run = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 8; k++) begin
            run = 1'($urandom_range(0, 1));
            CY  = 1'($urandom_range(0, 1));
            #1;
            chk("halt_pm_addr", pm_addr, 8'h01);
            chk("halt_alucode", ALUCode, 3'd7);
            chk("halt_r", R, 8'h12);
            chk("halt_a_ce", A_CE, 1'b0);
            chk("halt_halted", halted, 1'b1);
            tick();
        end
        do_reset();
        chk("unhalt_pm_addr", pm_addr, 8'h00);
        chk("unhalt_halted", halted, 1'b0);

        // ---- randomized programs against the instruction-level model ----
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 256; i++) begin
                if ($urandom_range(0, 1) == 0)
                    pmem[i] = 12'($urandom_range(0, 12'h7FF));
                else if ($urandom_range(0, 40) == 0)
                    pmem[i] = {4'hF, 8'($urandom)};
                else
                    pmem[i] = {1'b1, 3'($urandom_range(0, 6)), 8'($urandom)};
            end
            run = 1'b1;
            do_reset();
            m_pc = 8'h00; m_ir = 12'h000; m_pending = 1'b0; m_stopped = 1'b0;
            for (int c = 0; c < 400; c++) begin
                run   = ($urandom_range(0, 3) != 0);
                CY    = 1'($urandom_range(0, 1));
                Reset = ($urandom_range(0, 63) == 0);
                #1;
                chk("rnd_pm_addr", pm_addr, m_pc);
                chk("rnd_alucode", ALUCode, m_ir[10:8]);
                chk("rnd_r", R, m_ir[7:0]);
                chk("rnd_a_ce", A_CE, m_pending && !m_ir[11] && !Reset);
                chk("rnd_cy_ce", CY_CE, m_pending && !m_ir[11] && !Reset);
                chk("rnd_halted", halted, m_stopped);
                @(posedge clk);
                if (Reset) begin
                    m_pc = 8'h00; m_ir = 12'h000; m_pending = 1'b0; m_stopped = 1'b0;
                end else if (m_stopped) begin
                    // nothing moves until reset
                end else if (m_pending) begin
                    m_pc      = after_exec(m_ir, m_pc, CY);
                    m_stopped = (m_ir[11:8] == 4'hF);
                    m_pending = 1'b0;
                end else if (run) begin
                    m_ir      = pmem[m_pc];
                    m_pending = 1'b1;
                end
                #1;
            end
            Reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 8-bit accumulator datapath. It fetches 12-bit instructions from an asynchronous program memory and decodes them. It drives the ALU operation code, the immediate R operand, and the clock enables of the accumulator and carry registers, and it applies conditional jumps on the carry flag. It is the controlling end of the ALU/Aku/Reg_CY datapath, which the bench previously drove by hand.

## Interface
- (no parameters; all widths fixed)
- clk  input  1  rising-edge clock shared with Aku and Reg_CY
- Reset  input  1  synchronous, active-high reset
- run  input  1  fetch permission; FETCH advances only while high
- pm_data  input  12  instruction word at pm_addr, valid combinationally in the same cycle
- CY  input  1  current carry flag (Reg_CY output)
- pm_addr  output  8  program counter
- ALUCode  output  3  ALU operation select
- R  output  8  immediate operand to ALU R input
- A_CE  output  1  accumulator clock enable
- CY_CE  output  1  carry register clock enable
- halted  output  1  high in HALT state

## Operation
- Instruction format: bit 11 = class. Class 0 (ALU): [10:8] ALUCode, [7:0] immediate. Class 1 (control): [10:8] op, [7:0] target.
- Control ops: 000 NOP; 001 JMP target; 010 JC (jump if CY=1); 011 JNC (jump if CY=0); 111 HALT; 100/101/110 execute as NOP.
- Internal registers: PC[7:0], IR[11:0], state in {FETCH, EXEC, HALT}.
- FETCH: if run=1, IR <= pm_data and go to EXEC. If run=0, stay in FETCH with PC and IR unchanged.
- EXEC, class 0: A_CE=1 and CY_CE=1 for this cycle only. PC <= PC+1. Go to FETCH.
- EXEC, class 1 jump taken: PC <= target. Not taken, or NOP: PC <= PC+1. Go to FETCH. A_CE=CY_CE=0.
- EXEC, HALT: PC is unchanged. Go to HALT.
- HALT: absorbing state. Only Reset leaves it. run is ignored. Enables stay 0.
- ALUCode = IR[10:8] and R = IR[7:0] in every state. Both are stable for the whole EXEC cycle.
- A_CE and CY_CE = (state==EXEC) & ~IR[11] & ~Reset. They are combinational, and Reset masks them in the same cycle.
- pm_addr = PC.
- PC arithmetic is modulo 256: PC+1 at 0xFF wraps to 0x00.
- CY is sampled during EXEC. A carry written by the previous ALU instruction's EXEC edge is visible to a following JC/JNC.

## Timing
- Reset (sampled high at a clk edge) sets PC=0x00, IR=0x000, state=FETCH.
- After that edge: pm_addr=0x00, ALUCode=0, R=0x00, A_CE=0, CY_CE=0, halted=0.
- Reset has priority over every state. Asserting it mid-EXEC suppresses that cycle's enables, so Aku and Reg_CY are not written.
- Each instruction takes 2 cycles when run is held high: FETCH, then EXEC.
- The Aku and CY registers capture the ALU result at the clk edge that ends EXEC.
- The new pm_addr is visible in the cycle after the EXEC edge.
- halted rises in the cycle after the EXEC edge of a HALT instruction.
- run is checked only in FETCH. Deasserting run during EXEC does not abort the instruction in progress.
- A jump to its own address is legal and loops with a 2-cycle period.

## Test plan
- Reset, then program {0x008 ALU code0 R=8, 0xF00 HALT}, run=1:
  - A_CE and CY_CE are high in exactly cycle 2.
  - ALUCode=0 and R=0x08 in that cycle.
  - halted=1 from cycle 5 on, and pm_addr stays 0x01.
- JC with CY=1 at address 0x05, target 0x20 -> pm_addr=0x20 after EXEC. The same test with CY=0 -> pm_addr=0x06. A_CE and CY_CE stay 0 in both cases.
- run=0 for 5 cycles in FETCH at PC=0x03 -> pm_addr is held at 0x03 and no enables fire. Raising run resumes normal execution.
- ALU instruction placed at 0xFF -> pm_addr wraps to 0x00 after its EXEC.
- Assert Reset during the EXEC of an ALU op -> A_CE=CY_CE=0 in that cycle. Then pm_addr=0x00 and state is FETCH.
- In HALT, toggle run and change CY -> all outputs stay constant until Reset. Reset returns pm_addr to 0x00 and halted to 0.
